// File: rtl/road_pkg.sv
// ----------------------------------------------------------------------------
// road_pkg
// Shared definitions for the scrolling-road blocks: fixed-point scale of
// speeds/positions, lane count, lane index type, spawner FSM states and a
// helper mapping a lane index to its left-edge X pixel.
// No ports.
// ----------------------------------------------------------------------------
package road_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int NUM_LANES              = 4;

    typedef logic [1:0] lane_t;

    typedef enum logic {
        RUN = 1'b0,
        REQ = 1'b1
    } spawn_state_t;

    // Left-edge X pixel of a lane (11-bit signed screen coordinate).
    function automatic logic signed [10:0] lane_to_x(input lane_t lane,
                                                     input int    left_x,
                                                     input int    pitch);
        return 11'(left_x + int'(lane) * pitch);
    endfunction

endpackage

// File: rtl/lane_lfsr.sv
// ----------------------------------------------------------------------------
// lane_lfsr
// Free-running 16-bit Galois LFSR (taps 16'hB400, shift right). Advances on
// every clock; only the asynchronous reset reloads the seed, so game restarts
// do not replay the same random sequence.
// Ports:
//   clk     in   system clock
//   resetN  in   asynchronous active-low reset
//   o_lfsr  out  current 16-bit state
// ----------------------------------------------------------------------------
module lane_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        resetN,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_lfsr <= SEED;
        else
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/obstacle_spawner.sv
// ----------------------------------------------------------------------------
// obstacle_spawner
// Integrates the per-frame scroll speed (px x FIXED_POINT_MULTIPLIER) into
// travelled distance and, every SPACING_PX road pixels, raises a spawn request
// with a pseudo-random lane and its X coordinate over a req/ack handshake.
//
// Ports:
//   clk, resetN         clock, asynchronous active-low reset
//   startOfFrame        one-cycle pulse per frame (Yspeed sampled here)
//   move_allow          game running; low freezes integration
//   restart_enable      synchronous restart (all state except the LFSR)
//   Yspeed[8:0]         scroll speed, px x 64 per frame
//   spawn_ack           mover accepted the current request
//   spawn_req           request pending
//   spawn_lane[1:0]     lane index, stable while spawn_req is high
//   spawn_x[10:0]       signed X of the lane left edge
//   distance_px[15:0]   total road pixels travelled (wraps)
//   missed_spawns[1:0]  spawn events dropped while busy (saturating)
//
// Build option: OBSTACLE_NO_REPEAT_EN -- when defined, a candidate lane equal
// to the previous latched lane is bumped to the next lane (mod 4).
// ----------------------------------------------------------------------------
module obstacle_spawner #(
    parameter int          SPACING_PX             = 160,
    parameter int          FIXED_POINT_MULTIPLIER = road_pkg::FIXED_POINT_MULTIPLIER,
    parameter int          ROAD_LEFT_X            = 200,
    parameter int          LANE_WIDTH             = 60,
    parameter logic [15:0] LFSR_SEED              = 16'hACE1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               move_allow,
    input  logic               restart_enable,
    input  logic [8:0]         Yspeed,
    input  logic               spawn_ack,
    output logic               spawn_req,
    output logic [1:0]         spawn_lane,
    output logic signed [10:0] spawn_x,
    output logic [15:0]        distance_px,
    output logic [1:0]         missed_spawns
);

    import road_pkg::*;

    localparam int          FRAC   = $clog2(FIXED_POINT_MULTIPLIER);
    localparam int          TOT_W  = 16 + FRAC;
    localparam logic [16:0] THRESH = 17'(SPACING_PX * FIXED_POINT_MULTIPLIER);

    // ---------------- random source ----------------
    logic [15:0] w_lfsr;
    logic        w_unused_lfsr;

    lane_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .resetN (resetN),
        .o_lfsr (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:2];

    // ---------------- state ----------------
    spawn_state_t        r_state;
    logic [15:0]         r_acc;
    logic [TOT_W-1:0]    r_tot;
    logic                r_pend;
    logic                r_spawn_req;
    lane_t               r_lane;     // also serves as prev_lane (same reset, same update)
    logic signed [10:0]  r_spawn_x;
    logic [1:0]          r_missed;

    // ---------------- distance integration ----------------
    logic        w_adv;
    logic [16:0] w_sum;
    logic        w_cross;

    assign w_adv   = startOfFrame && move_allow;
    assign w_sum   = {1'b0, r_acc} + {8'b0, Yspeed};
    assign w_cross = w_adv && (w_sum >= THRESH);

    // ---------------- lane choice ----------------
    lane_t w_cand;
    lane_t w_lane;

    assign w_cand = lane_t'(w_lfsr[1:0]);
`ifdef OBSTACLE_NO_REPEAT_EN
    assign w_lane = (w_cand == r_lane) ? lane_t'(w_cand + 2'd1) : w_cand;
`else
    assign w_lane = w_cand;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= RUN;
            r_acc       <= '0;
            r_tot       <= '0;
            r_pend      <= 1'b0;
            r_spawn_req <= 1'b0;
            r_lane      <= '0;
            r_spawn_x   <= 11'(ROAD_LEFT_X);
            r_missed    <= '0;
        end else if (restart_enable) begin
            r_state     <= RUN;
            r_acc       <= '0;
            r_tot       <= '0;
            r_pend      <= 1'b0;
            r_spawn_req <= 1'b0;
            r_lane      <= '0;
            r_spawn_x   <= 11'(ROAD_LEFT_X);
            r_missed    <= '0;
        end else begin
            if (w_adv) begin
                // Keep the remainder past the threshold so spacing stays exact.
                r_acc <= w_cross ? 16'(w_sum - THRESH) : w_sum[15:0];
                r_tot <= r_tot + TOT_W'(Yspeed);
            end

            unique case (r_state)
                RUN: begin
                    if (r_pend || w_cross) begin
                        r_state     <= REQ;
                        r_spawn_req <= 1'b1;
                        r_lane      <= w_lane;
                        r_spawn_x   <= lane_to_x(w_lane, ROAD_LEFT_X, LANE_WIDTH);
                        // A crossing landing on the pend-consume cycle refills pend.
                        r_pend      <= r_pend && w_cross;
                    end
                end
                REQ: begin
                    if (spawn_ack) begin
                        r_state     <= RUN;
                        r_spawn_req <= 1'b0;
                        if (w_cross)
                            r_pend <= 1'b1;
                    end else if (w_cross && (r_missed != 2'd3)) begin
                        r_missed <= r_missed + 2'd1;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_spawn_req <= 1'b0;
                end
            endcase
        end
    end

    assign spawn_req     = r_spawn_req;
    assign spawn_lane    = r_lane;
    assign spawn_x       = r_spawn_x;
    assign distance_px   = r_tot[FRAC +: 16];
    assign missed_spawns = r_missed;

endmodule

// File: tb/tb_obstacle_spawner.sv
module tb_obstacle_spawner;

    localparam logic [15:0] SEED = 16'hACE1;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               move_allow = 1'b0;
    logic               restart_enable = 1'b0;
    logic [8:0]         Yspeed = '0;
    logic               spawn_ack = 1'b0;
    logic               spawn_req;
    logic [1:0]         spawn_lane;
    logic signed [10:0] spawn_x;
    logic [15:0]        distance_px;
    logic [1:0]         missed_spawns;

    obstacle_spawner dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .move_allow     (move_allow),
        .restart_enable (restart_enable),
        .Yspeed         (Yspeed),
        .spawn_ack      (spawn_ack),
        .spawn_req      (spawn_req),
        .spawn_lane     (spawn_lane),
        .spawn_x        (spawn_x),
        .distance_px    (distance_px),
        .missed_spawns  (missed_spawns)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR; m_prev holds the value seen before the last edge.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_lane(input logic [1:0] cand, input logic [1:0] prev);
`ifdef OBSTACLE_NO_REPEAT_EN
        return (cand == prev) ? cand + 2'd1 : cand;
`else
        return (prev == 2'd0) ? cand : cand;
`endif
    endfunction

    function automatic int lane_x(input logic [1:0] l);
        return 200 + 60 * int'(l);
    endfunction

    // One frame: pulse startOfFrame for one cycle; returns just after its edge.
    task automatic frame();
        @(negedge clk) startOfFrame = 1'b1;
        @(negedge clk) startOfFrame = 1'b0;
    endtask

    task automatic restart();
        @(negedge clk) restart_enable = 1'b1;
        @(negedge clk) restart_enable = 1'b0;
    endtask

    typedef struct {
        logic [8:0]  yspeed;
        int          frames;
        logic [15:0] exp_dist;
        logic        exp_req;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [1:0] lane0, prev, el;
        int spawns, repeats, budget;

        vecs[0] = '{9'd64,  159, 16'd159, 1'b0};
        vecs[1] = '{9'd64,  160, 16'd160, 1'b1};
        vecs[2] = '{9'd230,  44, 16'd158, 1'b0};
        vecs[3] = '{9'd230,  45, 16'd161, 1'b1};
        vecs[4] = '{9'd511,  20, 16'd159, 1'b0};
        vecs[5] = '{9'd511,  21, 16'd167, 1'b1};
        vecs[6] = '{9'd0,    50, 16'd0,   1'b0};
        vecs[7] = '{9'd100, 103, 16'd160, 1'b1};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_req",    32'(spawn_req), 32'd0);
        chk("rst_lane",   32'(spawn_lane), 32'd0);
        chk("rst_x",      32'(spawn_x), 32'd200);
        chk("rst_dist",   32'(distance_px), 32'd0);
        chk("rst_missed", 32'(missed_spawns), 32'd0);
        resetN = 1'b1;
        move_allow = 1'b1;

        // ---- table: distance and first-crossing frame, ack tied high ----
        spawn_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            restart();
            Yspeed = vecs[i].yspeed;
            repeat (vecs[i].frames) frame();
            chk($sformatf("vec%0d_dist", i), 32'(distance_px), 32'(vecs[i].exp_dist));
            chk($sformatf("vec%0d_req", i),  32'(spawn_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                chk($sformatf("vec%0d_lane", i), 32'(spawn_lane), 32'(exp_lane(m_prev[1:0], 2'd0)));
                chk($sformatf("vec%0d_x", i), 32'(spawn_x), 32'(lane_x(spawn_lane)));
            end
        end

        // ---- move_allow low freezes integration ----
        restart();
        Yspeed = 9'd511;
        move_allow = 1'b0;
        repeat (30) frame();
        chk("frozen_dist", 32'(distance_px), 32'd0);
        chk("frozen_req",  32'(spawn_req), 32'd0);
        move_allow = 1'b1;

        // ---- missed spawns saturate, lane held ----
        restart();
        spawn_ack = 1'b0;
        Yspeed = 9'd64;
        repeat (160) frame();
        chk("miss_first_req", 32'(spawn_req), 32'd1);
        lane0 = spawn_lane;
        for (int k = 1; k <= 5; k++) begin
            repeat (160) frame();
            chk($sformatf("miss%0d_cnt", k),  32'(missed_spawns), 32'((k < 3) ? k : 3));
            chk($sformatf("miss%0d_lane", k), 32'(spawn_lane), 32'(lane0));
            chk($sformatf("miss%0d_req", k),  32'(spawn_req), 32'd1);
        end

        // ---- ack in the same cycle as a crossing: one-cycle gap, new lane ----
        repeat (159) frame();
        @(negedge clk) begin startOfFrame = 1'b1; spawn_ack = 1'b1; end
        @(negedge clk) begin startOfFrame = 1'b0; spawn_ack = 1'b0; end
        chk("pend_gap_req",  32'(spawn_req), 32'd0);
        chk("pend_missed",   32'(missed_spawns), 32'd3);
        @(negedge clk);
        chk("pend_req_again", 32'(spawn_req), 32'd1);
        chk("pend_lane",      32'(spawn_lane), 32'(exp_lane(m_prev[1:0], lane0)));
        chk("pend_x",         32'(spawn_x), 32'(lane_x(spawn_lane)));
        @(negedge clk);
        chk("pend_req_hold",  32'(spawn_req), 32'd1);

        // ---- restart mid-REQ ----
        @(negedge clk) restart_enable = 1'b1;
        @(negedge clk) restart_enable = 1'b0;
        chk("rs_req",     32'(spawn_req), 32'd0);
        chk("rs_dist",    32'(distance_px), 32'd0);
        chk("rs_missed",  32'(missed_spawns), 32'd0);
        chk("rs_x",       32'(spawn_x), 32'd200);
        chk("rs_lfsr_not_seed", 32'(dut.u_lfsr.o_lfsr != SEED), 32'd1);
        chk("rs_lfsr_model",    32'(dut.u_lfsr.o_lfsr), 32'(m_lfsr));

        // ---- 256 spawns: lane sequence and X values ----
        spawn_ack = 1'b1;
        Yspeed = 9'd511;
        prev = 2'd0;
        spawns = 0;
        repeats = 0;
        budget = 256 * 25;
        while (spawns < 256 && budget > 0) begin
            frame();
            budget--;
            if (spawn_req) begin
                spawns++;
                el = exp_lane(m_prev[1:0], prev);
                chk($sformatf("sp%0d_lane", spawns), 32'(spawn_lane), 32'(el));
                chk($sformatf("sp%0d_x", spawns), 32'(spawn_x), 32'(lane_x(spawn_lane)));
                if (spawns > 1 && spawn_lane == prev) repeats++;
                prev = spawn_lane;
            end
        end
        chk("sp_count", 32'(spawns), 32'd256);
`ifdef OBSTACLE_NO_REPEAT_EN
        chk("sp_repeats", 32'(repeats), 32'd0);
`else
        chk("sp_has_repeat", 32'(repeats > 0), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
